// File: rtl/eeprom_cmd_sched.sv
// Command scheduler for an I2C EEPROM master: queues read/write commands,
// launches them one at a time, retries NACKs, enforces write-cycle guard time.
module eeprom_cmd_sched #(
    parameter int DEPTH      = 4,
    parameter int TWR_CYCLES = 250000,
    parameter int MAX_RETRY  = 3,
    parameter int TMO_CYCLES = 1048575
) (
    input  logic        clk_50M,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [15:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        m_start,
    output logic        m_rw,
    output logic [15:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic        m_busy,
    input  logic        m_done,
    input  logic        m_ack_error,
    input  logic [7:0]  m_rdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_rw,
    output logic [15:0] rsp_addr,
    output logic [7:0]  rsp_data,
    output logic        rsp_err,
    output logic        rsp_tmo
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [19:0] TWR_LAST = 20'(TWR_CYCLES - 1);
    localparam logic [19:0] TMO_LAST = 20'(TMO_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP, GUARD} state_t;
    state_t state, state_nx;

    logic [24:0]   mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic          full, empty, push, pop;
    logic [RW-1:0] retry;
    logic [19:0]   cnt;
    logic          retry_pend;
    logic          nack_retry, load_rsp, tmo_hit;
    logic          w_rw;
    logic [15:0]   w_addr;
    logic [7:0]    w_wdata;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty     = (wptr == rptr);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty;

    assign m_rw    = w_rw;
    assign m_addr  = w_addr;
    assign m_wdata = w_wdata;

    always_ff @(posedge clk_50M) begin
        if (push) mem[wptr[AW-1:0]] <= {cmd_rw, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk_50M or negedge rstn) begin
        if (!rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        m_start    = 1'b0;
        rsp_valid  = 1'b0;
        nack_retry = 1'b0;
        load_rsp   = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE:  if (!empty) state_nx = ISSUE;
            ISSUE: begin
                m_start  = 1'b1;
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY, WAIT_DONE: begin
                // m_done wins over busy so a very short transaction is not missed.
                if (m_done) begin
                    if (m_ack_error && (retry < RW'(MAX_RETRY))) begin
                        nack_retry = 1'b1;
                        state_nx   = GUARD;
                    end else begin
                        load_rsp = 1'b1;
                        state_nx = RESP;
                    end
                end else if (cnt == TMO_LAST) begin
                    tmo_hit  = 1'b1;
                    load_rsp = 1'b1;
                    state_nx = RESP;
                end else if (state == WAIT_BUSY && m_busy) begin
                    state_nx = WAIT_DONE;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = (!rsp_rw && !rsp_err) ? GUARD : IDLE;
            end
            GUARD: if (cnt == TWR_LAST) state_nx = retry_pend ? ISSUE : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            retry      <= '0;
            cnt        <= '0;
            retry_pend <= 1'b0;
            w_rw       <= 1'b0;
            w_addr     <= '0;
            w_wdata    <= '0;
            rsp_rw     <= 1'b0;
            rsp_addr   <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            rsp_tmo    <= 1'b0;
        end else begin
            state <= state_nx;
            // One counter: timeout while waiting, write-cycle time while guarding.
            if (state_nx != state && (state_nx == ISSUE || state_nx == GUARD))
                cnt <= '0;
            else if (state == WAIT_BUSY || state == WAIT_DONE || state == GUARD)
                cnt <= cnt + 20'd1;
            if (pop) begin
                {w_rw, w_addr, w_wdata} <= mem[rptr[AW-1:0]];
                retry      <= '0;
                retry_pend <= 1'b0;
            end
            if (nack_retry) begin
                retry      <= retry + 1'b1;
                retry_pend <= 1'b1;
            end
            if (state == RESP && rsp_ready) retry_pend <= 1'b0;
            if (load_rsp) begin
                rsp_rw   <= w_rw;
                rsp_addr <= w_addr;
                rsp_data <= (w_rw && !tmo_hit) ? m_rdata : 8'h00;
                rsp_err  <= tmo_hit | m_ack_error;
                rsp_tmo  <= tmo_hit;
            end
        end
    end

endmodule

// File: tb/tb_eeprom_cmd_sched.sv
// Bench for eeprom_cmd_sched: scripted I2C master model, vector table,
// randomized commands against a retry/response model, plus FIFO/timeout/reset sequences.
module tb_eeprom_cmd_sched;

    localparam int DEPTH = 4;
    localparam int TWR   = 20;
    localparam int MAXR  = 3;
    localparam int TMO   = 200;

    logic        clk_50M, rstn;
    logic        cmd_valid, cmd_ready, cmd_rw;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        m_start, m_rw, m_busy, m_done, m_ack_error;
    logic [15:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;
    logic        rsp_valid, rsp_ready, rsp_rw, rsp_err, rsp_tmo;
    logic [15:0] rsp_addr;
    logic [7:0]  rsp_data;

    eeprom_cmd_sched #(.DEPTH(DEPTH), .TWR_CYCLES(TWR), .MAX_RETRY(MAXR), .TMO_CYCLES(TMO)) dut (
        .clk_50M(clk_50M), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .m_start(m_start), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_busy(m_busy), .m_done(m_done), .m_ack_error(m_ack_error), .m_rdata(m_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rw(rsp_rw),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_tmo(rsp_tmo)
    );

    initial begin
        clk_50M = 1'b0;
        forever #10 clk_50M = ~clk_50M;
    end

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    always @(posedge clk_50M) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_rng(input string nm, input int val, input int lo, input int hi);
        n_chk++;
        if (val < lo || val > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, val, lo, hi);
        end
    endtask

    // Master model: mode 0 = answer with scripted NACKs, 1 = ignore, 2 = busy forever.
    int         bfm_mode = 0, bfm_nacks = 0, bfm_lat = 0;
    logic [7:0] bfm_rdata = 8'h00;

    initial begin
        m_busy = 1'b0; m_done = 1'b0; m_ack_error = 1'b0; m_rdata = 8'h00;
        forever begin
            @(posedge clk_50M); #1;
            if (m_start && bfm_mode == 0) begin
                repeat (bfm_lat) begin @(posedge clk_50M); #1; m_busy = 1'b1; end
                @(posedge clk_50M); #1;
                m_busy = 1'b0; m_done = 1'b1;
                m_ack_error = (bfm_nacks > 0);
                m_rdata = (bfm_nacks > 0) ? 8'hEE : bfm_rdata;
                if (bfm_nacks > 0) bfm_nacks--;
                @(posedge clk_50M); #1;
                m_done = 1'b0; m_ack_error = 1'b0; m_rdata = 8'h00;
            end else if (m_start && bfm_mode == 2) begin
                m_busy = 1'b1;
            end
        end
    end

    // Launch monitor: counts pulses, records the first launch, checks spacing.
    int          starts = 0, fs_cyc = 0, ls_cyc = 0, hs_cyc = 0;
    logic        fs_rw;
    logic [15:0] fs_addr;
    logic [7:0]  fs_wd;
    bit          gap_en = 0, prev_wsucc = 0;

    always @(negedge clk_50M) begin
        if (rstn && m_start) begin
            starts++;
            if (starts == 1) begin
                fs_cyc = cyc; fs_rw = m_rw; fs_addr = m_addr; fs_wd = m_wdata;
                if (gap_en && prev_wsucc) chk_rng("guard_gap", cyc - hs_cyc, TWR + 1, 100000);
            end else if (gap_en) begin
                chk_rng("retry_gap", cyc - ls_cyc, TWR, 100000);
            end
            ls_cyc = cyc;
        end
    end

    logic        r_rw, r_err, r_tmo;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    int          rsp_cyc = 0;

    task automatic push(input logic rw, input logic [15:0] a, input logic [7:0] d,
                        input int tries, output bit ok);
        cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_wdata = d;
        ok = 0;
        for (int i = 0; i < tries && !ok; i++) begin
            @(negedge clk_50M);
            if (cmd_ready) ok = 1;
            @(posedge clk_50M); #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int bound, output bit ok);
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk_50M);
            if (rsp_valid) ok = 1;
        end
        if (ok) begin
            r_rw = rsp_rw; r_addr = rsp_addr; r_data = rsp_data;
            r_err = rsp_err; r_tmo = rsp_tmo; rsp_cyc = cyc;
        end
    endtask

    task automatic run_cmd(input string tag, input logic rw, input logic [15:0] a,
                           input logic [7:0] wd, input int nacks, input logic [7:0] rd,
                           input int lat, input int e_starts, input logic e_err,
                           input logic [7:0] e_data);
        bit ok;
        bfm_mode = 0; bfm_nacks = nacks; bfm_rdata = rd; bfm_lat = lat;
        starts = 0; gap_en = 1;
        push(rw, a, wd, 50, ok);
        chk({tag, ".push"}, 32'(ok), 1);
        wait_rsp(4000, ok);
        chk({tag, ".rsp"}, 32'(ok), 1);
        @(posedge clk_50M); #1;
        gap_en = 0;
        chk({tag, ".starts"}, starts, e_starts);
        chk({tag, ".m_rw"}, 32'(fs_rw), 32'(rw));
        chk({tag, ".m_addr"}, 32'(fs_addr), 32'(a));
        chk({tag, ".m_wdata"}, 32'(fs_wd), 32'(wd));
        chk({tag, ".rsp_rw"}, 32'(r_rw), 32'(rw));
        chk({tag, ".rsp_addr"}, 32'(r_addr), 32'(a));
        chk({tag, ".rsp_data"}, 32'(r_data), 32'(e_data));
        chk({tag, ".rsp_err"}, 32'(r_err), 32'(e_err));
        chk({tag, ".rsp_tmo"}, 32'(r_tmo), 0);
        prev_wsucc = ok && !rw && !r_err;
        hs_cyc = rsp_cyc;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".cmd_ready"}, 32'(cmd_ready), 1);
        chk({tag, ".m_start"}, 32'(m_start), 0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, ".m_fields"}, {15'd0, m_rw, m_addr}, 0);
        chk({tag, ".m_wdata"}, 32'(m_wdata), 0);
        chk({tag, ".rsp_fields"}, {rsp_rw, rsp_err, rsp_tmo, rsp_data, rsp_addr}, 0);
    endtask

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          nacks;
        logic [7:0]  rdata;
        int          lat;
        int          e_starts;
        logic        e_err;
        logic [7:0]  e_data;
    } vec_t;

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        bit   ok;
        int   accepted, diffs, seen;
        tbl[0] = '{1'b0, 16'h4813, 8'hD1, 0, 8'h00, 2, 1, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 16'h4813, 8'h00, 0, 8'hD1, 1, 1, 1'b0, 8'hD1};
        tbl[2] = '{1'b0, 16'h00A5, 8'h3C, 4, 8'h00, 1, 4, 1'b1, 8'h00};
        tbl[3] = '{1'b1, 16'h1234, 8'h00, 2, 8'h5A, 0, 3, 1'b0, 8'h5A};
        tbl[4] = '{1'b1, 16'hFFFF, 8'h99, 5, 8'h77, 3, 4, 1'b1, 8'hEE};
        tbl[5] = '{1'b0, 16'h0000, 8'hFF, 3, 8'h00, 2, 4, 1'b0, 8'h00};

        cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 16'h0; cmd_wdata = 8'h0;
        rsp_ready = 1'b1;
        rstn = 1'b1;
        #3 rstn = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1 chk_reset_outputs("reset");
        @(negedge clk_50M) rstn = 1'b1;
        @(posedge clk_50M); #1;

        foreach (tbl[i])
            run_cmd($sformatf("vec%0d", i), tbl[i].rw, tbl[i].addr, tbl[i].wdata,
                    tbl[i].nacks, tbl[i].rdata, tbl[i].lat,
                    tbl[i].e_starts, tbl[i].e_err, tbl[i].e_data);

        // Model: NACKs beyond the retry budget end in an error; a NACKed read returns the bus byte.
        for (int i = 0; i < 12; i++) begin
            logic       rw;
            logic [7:0] rd;
            int         n, e_starts;
            logic       e_err;
            rw = 1'($urandom_range(0, 1));
            rd = 8'($urandom);
            n  = $urandom_range(0, 5);
            e_err    = (n > MAXR);
            e_starts = e_err ? MAXR + 1 : n + 1;
            run_cmd($sformatf("rnd%0d", i), rw, 16'($urandom), 8'($urandom), n, rd,
                    $urandom_range(0, 3), e_starts, e_err,
                    rw ? (e_err ? 8'hEE : rd) : 8'h00);
        end

        // Silent master: queue fills behind the stuck command, then it times out.
        prev_wsucc = 0; gap_en = 0;
        bfm_mode = 1; rsp_ready = 1'b0; starts = 0;
        push(1'b1, 16'h1000, 8'h00, 50, ok);
        for (int i = 0; i < 20 && starts == 0; i++) @(negedge clk_50M);
        chk("tmo.first_start", starts, 1);
        @(posedge clk_50M); #1;
        accepted = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            push(1'b0, 16'h2000 + 16'(i), 8'(i), 3, ok);
            if (ok) accepted++;
        end
        chk("fifo.accepted", accepted, DEPTH);
        chk("fifo.ready_low", 32'(cmd_ready), 0);
        wait_rsp(TMO + 50, ok);
        chk("tmo.rsp", 32'(ok), 1);
        chk_rng("tmo.latency", rsp_cyc - fs_cyc, TMO, TMO + 2);
        chk("tmo.err_tmo", {r_err, r_tmo}, 2'b11);
        chk("tmo.addr", 32'(r_addr), 32'h1000);

        diffs = 0;
        repeat (1000) begin
            @(negedge clk_50M);
            if (!rsp_valid || rsp_rw !== r_rw || rsp_addr !== r_addr || rsp_data !== r_data ||
                rsp_err !== r_err || rsp_tmo !== r_tmo) diffs++;
        end
        chk("hold.stable", diffs, 0);
        chk("hold.no_start", starts, 1);

        // Next queued command sticks in WAIT_DONE; reset there drops it and the queue.
        bfm_mode = 2; starts = 0;
        @(posedge clk_50M); #1 rsp_ready = 1'b1;
        for (int i = 0; i < 20 && starts == 0; i++) @(negedge clk_50M);
        chk("rst.issued", starts, 1);
        repeat (5) @(posedge clk_50M);
        #1 rstn = 1'b0;
        #1 chk_reset_outputs("rst_mid");
        m_busy = 1'b0; bfm_mode = 0;
        repeat (2) @(posedge clk_50M);
        @(negedge clk_50M) rstn = 1'b1;
        seen = 0;
        repeat (300) begin
            @(negedge clk_50M);
            if (rsp_valid) seen++;
        end
        chk("rst.no_rsp", seen, 0);
        chk("rst.no_start", starts, 1);
        chk("rst.ready", 32'(cmd_ready), 1);

        @(posedge clk_50M); #1;
        prev_wsucc = 0;
        run_cmd("after_rst", 1'b1, 16'h0ABC, 8'h00, 0, 8'h3E, 1, 1, 1'b0, 8'h3E);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
